// File: rtl/vpu_sram_rd_responder_if.sv
// VPU-side read-port bundle between the VPU source-port initiator and the SRAM read responder.
// The VPU side drives the request and beat strobes; the responder returns the grant and the read data.
interface vpu_sram_rd_responder_if #(
    parameter int BANK_LG2  = 5,
    parameter int DEPTH_LG2 = 9,
    parameter int DW        = 512
);
    logic                 req_i;
    logic [BANK_LG2-1:0]  rid_i;
    logic [DEPTH_LG2-1:0] addr_i;
    logic                 reb_i;
    logic                 rlast_i;
    logic                 ack_o;
    logic [DW-1:0]        rdata_o;
    logic                 rvalid_o;

    // Handshake: req_i is held until ack_o pulses for one cycle; after that one
    // beat is issued in every cycle with reb_i==0, rlast_i marks the final beat,
    // and every issued beat returns exactly once on rvalid_o.
    modport master (
        output req_i, rid_i, addr_i, reb_i, rlast_i,
        input  ack_o, rdata_o, rvalid_o
    );

    modport slave (
        input  req_i, rid_i, addr_i, reb_i, rlast_i,
        output ack_o, rdata_o, rvalid_o
    );
endinterface

// File: rtl/vpu_sram_rd_responder.sv
// SRAM-side read responder: locks one bank per burst, turns beats into bank strobes and
// returns bank data with a fixed pipeline latency until the burst has fully drained.
module vpu_sram_rd_responder #(
    parameter int SRAM_BANK_CNT_LG2   = 5,
    parameter int SRAM_BANK_DEPTH_LG2 = 9,
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int RD_LATENCY          = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    vpu_sram_rd_responder_if.slave            vpu,
    input  logic [2**SRAM_BANK_CNT_LG2-1:0]   bank_busy_i,
    output logic [2**SRAM_BANK_CNT_LG2-1:0]   bank_lock_o,
    output logic [2**SRAM_BANK_CNT_LG2-1:0]   bank_cs_o,
    output logic [SRAM_BANK_DEPTH_LG2-1:0]    bank_addr_o,
    input  logic [SRAM_DATA_WIDTH-1:0]        bank_rdata_i,
    output logic                              err_o,
    output logic [1:0]                        dbg_state_o
);
    localparam int NB = 2**SRAM_BANK_CNT_LG2;
    localparam int CW = SRAM_BANK_DEPTH_LG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SRAM_BANK_CNT_LG2-1:0]   r_rid;
    logic [RD_LATENCY-1:0]          r_vpipe;
    logic [CW-1:0]                  r_cnt;
    logic                           r_rvalid;
    logic [SRAM_DATA_WIDTH-1:0]     r_rdata;
    logic                           r_err;

    logic                           w_issue;
    logic                           w_pop;
    logic                           w_accept;
    logic                           w_ack;
    logic                           w_err_set;
    logic [NB-1:0]                  w_onehot;

    assign w_onehot = NB'(1) << r_rid;
    assign w_pop    = r_vpipe[RD_LATENCY-1];

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_set = ~vpu.reb_i;
                if (vpu.req_i && !bank_busy_i[vpu.rid_i]) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_ack       = 1'b1;
                w_err_set   = ~vpu.reb_i;
                w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (!vpu.reb_i) begin
                    w_issue = 1'b1;
                    if (vpu.rlast_i) w_state_nxt = S_DRAIN;
                end else if (vpu.rlast_i) begin
                    w_err_set = 1'b1;
                end
            end
            S_DRAIN: begin
                w_err_set = ~vpu.reb_i;
                // Leave only once every issued beat has been handed to the output register.
                if (r_cnt == '0 && r_vpipe == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rid    <= '0;
            r_vpipe  <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_rid <= vpu.rid_i;
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];
            case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_rvalid <= w_pop;
            if (w_pop) r_rdata <= bank_rdata_i;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign vpu.ack_o    = w_ack;
    assign vpu.rvalid_o = r_rvalid;
    assign vpu.rdata_o  = r_rdata;
    assign bank_lock_o  = (r_state != S_IDLE) ? w_onehot : '0;
    assign bank_cs_o    = w_issue ? w_onehot : '0;
    assign bank_addr_o  = w_issue ? vpu.addr_i : '0;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// Bench for vpu_sram_rd_responder: random bursts checked cycle by cycle against a
// timing-rule reference model, with a behavioural SRAM bank array behind the DUT.
module tb_vpu_sram_rd_responder;
    localparam int LG2   = 5;
    localparam int DEPTH = 9;
    localparam int DW    = 512;
    localparam int RDL   = 2;
    localparam int NB    = 32;
    localparam int RING  = 16;
    localparam int NEVER = 32'h7fffffff;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NB-1:0]    bank_busy;
    logic [NB-1:0]    bank_lock;
    logic [NB-1:0]    bank_cs;
    logic [DEPTH-1:0] bank_addr;
    logic [DW-1:0]    bank_rdata;
    logic             err;
    logic [1:0]       dbg_state;

    vpu_sram_rd_responder_if #(.BANK_LG2(LG2), .DEPTH_LG2(DEPTH), .DW(DW)) vif ();

    vpu_sram_rd_responder #(
        .SRAM_BANK_CNT_LG2(LG2), .SRAM_BANK_DEPTH_LG2(DEPTH),
        .SRAM_DATA_WIDTH(DW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vpu(vif),
        .bank_busy_i(bank_busy), .bank_lock_o(bank_lock), .bank_cs_o(bank_cs),
        .bank_addr_o(bank_addr), .bank_rdata_i(bank_rdata), .err_o(err),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model
    bit            m_granted;
    int            m_ack_cyc;
    int            m_idle_cyc;
    int            m_bank;
    bit            m_last_seen;
    bit            m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] exp_q[$];
    int            exp_t_q[$];
    bit            obs_ack;

    // behavioural SRAM delay line
    bit               sram_v[RING];
    int               sram_b[RING];
    logic [DEPTH-1:0] sram_a[RING];

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem(input int b, input logic [DEPTH-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++)
            d[i*32 +: 32] = (32'(b) * 32'h01000193) ^ (32'(a) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B);
        return d;
    endfunction

    task automatic model_clear();
        m_granted   = 1'b0;
        m_ack_cyc   = NEVER;
        m_idle_cyc  = NEVER;
        m_last_seen = 1'b0;
        m_err       = 1'b0;
        m_rdata     = '0;
        exp_q.delete();
        exp_t_q.delete();
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_ack"},    vif.ack_o,    '0);
        check_val({pfx, "_lock"},   bank_lock,    '0);
        check_val({pfx, "_cs"},     bank_cs,      '0);
        check_val({pfx, "_addr"},   bank_addr,    '0);
        check_val({pfx, "_rvalid"}, vif.rvalid_o, '0);
        check_val({pfx, "_rdata"},  vif.rdata_o,  '0);
        check_val({pfx, "_err"},    err,          '0);
    endtask

    // One clock cycle: inputs are already driven; check at negedge, advance the model, clock.
    task automatic step();
        bit        owned, in_ack, in_burst, issue, rv_now;
        logic [NB-1:0] oh;
        int        bi, j;
        @(negedge clk);
        if (!rst_n) begin
            check_zero("rst");
            model_clear();
            obs_ack = 1'b0;
        end else begin
            owned    = m_granted && cyc >= m_ack_cyc && cyc < m_idle_cyc;
            in_ack   = owned && cyc == m_ack_cyc;
            in_burst = owned && cyc > m_ack_cyc && !m_last_seen;
            issue    = in_burst && !vif.reb_i;
            oh       = NB'(1) << m_bank;
            rv_now   = exp_t_q.size() > 0 && exp_t_q[0] == cyc;
            if (rv_now) begin
                m_rdata = exp_q.pop_front();
                void'(exp_t_q.pop_front());
            end
            check_val("ack",    vif.ack_o,    in_ack);
            check_val("lock",   bank_lock,    owned ? oh : '0);
            check_val("cs",     bank_cs,      issue ? oh : '0);
            check_val("addr",   bank_addr,    issue ? vif.addr_i : '0);
            check_val("rvalid", vif.rvalid_o, rv_now);
            check_val("rdata",  vif.rdata_o,  m_rdata);
            check_val("err",    err,          m_err);
            obs_ack = vif.ack_o;
            if (issue) begin
                exp_q.push_back(mem(m_bank, vif.addr_i));
                exp_t_q.push_back(cyc + RDL + 1);
                if (vif.rlast_i) begin
                    m_last_seen = 1'b1;
                    m_idle_cyc  = cyc + RDL + 2;
                end
            end
            if ((!vif.reb_i && !issue) || (in_burst && vif.reb_i && vif.rlast_i)) m_err = 1'b1;
            if (!owned && vif.req_i && !bank_busy[vif.rid_i]) begin
                m_granted   = 1'b1;
                m_ack_cyc   = cyc + 1;
                m_idle_cyc  = NEVER;
                m_last_seen = 1'b0;
                m_bank      = int'(vif.rid_i);
            end
        end
        bi = 0;
        for (int i = 0; i < NB; i++) if (bank_cs[i]) bi = i;
        sram_v[cyc % RING] = |bank_cs;
        sram_b[cyc % RING] = bi;
        sram_a[cyc % RING] = bank_addr;
        @(posedge clk);
        #1;
        cyc++;
        j = cyc - RDL;
        if (j >= 0 && sram_v[j % RING]) bank_rdata = mem(sram_b[j % RING], sram_a[j % RING]);
        else bank_rdata = {16{$urandom}};
    endtask

    task automatic apply_reset();
        vif.req_i   = 1'b0;
        vif.reb_i   = 1'b1;
        vif.rlast_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        vif.req_i   = 1'b0;
        vif.reb_i   = 1'b1;
        vif.rlast_i = 1'b0;
        repeat (n) begin
            bank_busy  = $urandom;
            vif.addr_i = DEPTH'($urandom);
            step();
        end
    endtask

    task automatic burst(input int rid, input int nbeats, input int gap_pct, input logic [15:0] pat,
                         input int busy_cyc, input int reset_at, input int chain_rid,
                         input bit bad_rlast, input bit bad_drain);
        int bc, waitn, k, s;
        bit beat;
        bc = busy_cyc;
        waitn = 0;
        obs_ack = 1'b0;
        vif.req_i   = 1'b1;
        vif.rid_i   = LG2'(rid);
        vif.reb_i   = 1'b1;
        vif.rlast_i = 1'b0;
        while (!obs_ack && waitn < 60) begin
            bank_busy      = $urandom;
            bank_busy[rid] = (bc > 0);
            bc--;
            vif.addr_i = DEPTH'($urandom);
            step();
            waitn++;
        end
        if (!obs_ack) begin
            check_val("ack_timeout", 1'b0, 1'b1);
            return;
        end
        k = 0;
        s = 0;
        while (k < nbeats) begin
            if (k == reset_at) begin
                apply_reset();
                return;
            end
            bank_busy  = $urandom;
            vif.req_i  = 1'($urandom);
            vif.rid_i  = LG2'($urandom);
            vif.addr_i = DEPTH'($urandom);
            if (pat != 0) beat = (s >= 16) ? 1'b1 : pat[s];
            else          beat = ($urandom_range(99, 0) >= gap_pct);
            if (beat) begin
                vif.reb_i   = 1'b0;
                vif.rlast_i = (k == nbeats - 1);
                k++;
            end else begin
                vif.reb_i   = 1'b1;
                vif.rlast_i = bad_rlast;
            end
            s++;
            step();
        end
        for (int i = 0; i <= RDL; i++) begin
            vif.req_i = (chain_rid >= 0);
            if (chain_rid >= 0) vif.rid_i = LG2'(chain_rid);
            vif.reb_i   = !(bad_drain && i == 0);
            vif.rlast_i = 1'b0;
            vif.addr_i  = DEPTH'($urandom);
            bank_busy   = $urandom;
            step();
        end
        vif.reb_i = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rid, nb, nxt;
        bit chain;
        rst_n       = 1'b0;
        vif.req_i   = 1'b0;
        vif.rid_i   = '0;
        vif.addr_i  = '0;
        vif.reb_i   = 1'b1;
        vif.rlast_i = 1'b0;
        bank_busy   = '0;
        bank_rdata  = '0;
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        idle(2);

        burst(3, 4, 0, 16'h0, 0, -1, -1, 1'b0, 1'b0);           // single contiguous burst
        burst(7, 2, 0, 16'h0, 5, -1, -1, 1'b0, 1'b0);           // requested bank busy first
        burst(5, 3, 0, 16'b100101, 0, -1, -1, 1'b0, 1'b0);      // gapped beats
        burst(9, 4, 0, 16'h0, 0, -1, 12, 1'b0, 1'b0);           // next request held in drain
        burst(12, 3, 0, 16'h0, 0, -1, -1, 1'b0, 1'b0);
        burst(1, 1, 0, 16'h0, 0, -1, -1, 1'b0, 1'b0);           // single-beat burst
        idle(2);

        nxt = $urandom_range(NB - 1, 0);
        for (int n = 0; n < 25; n++) begin
            rid   = nxt;
            nb    = $urandom_range(8, 1);
            nxt   = $urandom_range(NB - 1, 0);
            chain = ($urandom_range(1, 0) == 1);
            burst(rid, nb, 30, 16'h0, chain ? 0 : $urandom_range(3, 0), -1,
                  chain ? nxt : -1, 1'b0, 1'b0);
            if (!chain) idle($urandom_range(2, 0));
        end
        idle(2);

        burst(4, 6, 0, 16'h0, 0, 2, -1, 1'b0, 1'b0);            // reset mid-burst
        idle(4);
        burst(4, 2, 0, 16'h0, 0, -1, -1, 1'b0, 1'b0);

        vif.reb_i  = 1'b0;                                      // stray beat while idle
        vif.addr_i = DEPTH'($urandom);
        step();
        idle(2);
        burst(2, 3, 0, 16'h0, 0, -1, -1, 1'b0, 1'b0);

        apply_reset();
        burst(6, 3, 0, 16'b11001, 0, -1, -1, 1'b1, 1'b0);       // rlast without a beat
        apply_reset();
        burst(8, 2, 0, 16'h0, 0, -1, -1, 1'b0, 1'b1);           // beat attempted in drain
        idle(3);
        apply_reset();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
